deser400_bit_recovery: RTL

- Consumer side of the deser400 phase loop.
- Takes the 8x-oversampled serial stream and the filtered 4*pi phase (5 bit, half steps, as produced by the phase detector filter).
- Picks one sample per bit period, handles bit duplication and skipping when the phase wraps, and packs the recovered bits into SYM_W-bit symbols for the downstream 4b/5b decoder.

---
 rtl/deser400_pkg.sv | 29 ++
 rtl/deser400_bit_packer.sv | 64 ++++++
 rtl/deser400_bit_recovery.sv | 125 ++++++++++++
 3 files changed

// File: rtl/deser400_pkg.sv
// Shared constants and the phase-step classifier for the deser400 bit recovery path.
package deser400_pkg;

    localparam int unsigned OVS     = 8;   // samples per bit period
    localparam int unsigned WIN_W   = 32;  // four-word sample history
    localparam int unsigned P_RESET = 8;   // p after reset (filter output 16)
    localparam int unsigned S_BASE  = 8;

    typedef enum logic [1:0] {
        SelNormal,
        SelDup,
        SelSkip,
        SelErr
    } sel_e;

    // Wraps at the 15/0 boundary are legal slips; any other jump >1 is an error.
    function automatic sel_e classify(input logic [3:0] p_prev, input logic [3:0] p_cur);
        logic [3:0] diff;
        if (p_prev == 4'd15 && p_cur == 4'd0) begin
            return SelDup;
        end
        if (p_prev == 4'd0 && p_cur == 4'd15) begin
            return SelSkip;
        end
        diff = (p_cur > p_prev) ? (p_cur - p_prev) : (p_prev - p_cur);
        return (diff > 4'd1) ? SelErr : SelNormal;
    endfunction

endpackage

// File: rtl/deser400_bit_packer.sv
// Packs 0..3 recovered bits per cycle into SYM_W-bit symbols, oldest bit in the MSB.
module deser400_bit_packer #(
    parameter int unsigned SYM_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       bits,
    input  logic [1:0]       n,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid
);

    localparam int unsigned ACC_W    = SYM_W + 2;
    localparam int unsigned CNT_BITS = $clog2(SYM_W + 3);

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    merged;
    logic [ACC_W-1:0]    keep_mask;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] total;
    logic [CNT_BITS-1:0] rem;
    logic [SYM_W-1:0]    sym_q, sym_d;
    logic                valid_q, valid_d;
    logic [2:0]          bits_m;

    // Accumulator bits above cnt_q are always zero, so new bits can be OR-ed in.
    always_comb begin
        bits_m    = bits & ~(3'b111 << n);
        merged    = (acc_q << n) | ACC_W'(bits_m);
        total     = cnt_q + CNT_BITS'(n);
        rem       = '0;
        keep_mask = '0;
        acc_d     = merged;
        cnt_d     = total;
        sym_d     = sym_q;
        valid_d   = 1'b0;
        if (total >= CNT_BITS'(SYM_W)) begin
            rem       = total - CNT_BITS'(SYM_W);
            keep_mask = ~({ACC_W{1'b1}} << rem);
            sym_d     = SYM_W'(merged >> rem);
            acc_d     = merged & keep_mask;
            cnt_d     = rem;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
        end
    end

    assign sym       = sym_q;
    assign sym_valid = valid_q;

endmodule

// File: rtl/deser400_bit_recovery.sv
// Recovers one bit per period from the 8x-oversampled stream using the filtered phase,
// absorbing phase wraps by dropping or adding bits, and packs bits into symbols.
module deser400_bit_recovery
    import deser400_pkg::*;
#(
    parameter int unsigned SYM_W = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sdata,
    input  logic [4:0]       phase,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    output logic             dup_evt,
    output logic             skip_evt,
    output logic             phase_err,
    output logic [CNT_W-1:0] dup_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    logic [WIN_W-1:0] win_q, win_d;
    logic [OVS-1:0]   sdata_rev;
    logic [3:0]       p_reg_q, p_reg_d;
    logic [3:0]       p_prev_q, p_prev_d;
    logic [4:0]       s_idx;
    sel_e             sel;
    logic [2:0]       bits_q, bits_d;
    logic [1:0]       n_q, n_d;
    logic             dup_q, dup_d;
    logic             skip_q, skip_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    // Stage 0: sdata[7] is the earliest sample, so it lands at the lowest new index.
    always_comb begin
        for (int k = 0; k < OVS; k++) begin
            sdata_rev[k] = sdata[OVS-1-k];
        end
        win_d    = {sdata_rev, win_q[WIN_W-1:OVS]};
        p_reg_d  = phase[4:1];
        p_prev_d = p_reg_q;
    end

    // Stage 1: sample selection and slip handling.
    always_comb begin
        s_idx  = 5'(S_BASE) + {1'b0, p_reg_q};
        sel    = classify(p_prev_q, p_reg_q);
        bits_d = {2'b00, win_q[s_idx]};
        n_d    = 2'd1;
        dup_d  = 1'b0;
        skip_d = 1'b0;
        err_d  = 1'b0;
        unique case (sel)
            SelNormal: ;
            SelDup: begin
                bits_d = '0;
                n_d    = 2'd0;
                dup_d  = 1'b1;
            end
            SelSkip: begin
                bits_d = {win_q[s_idx - 5'd16], win_q[s_idx - 5'd8], win_q[s_idx]};
                n_d    = 2'd3;
                skip_d = 1'b1;
            end
            SelErr: err_d = 1'b1;
        endcase
    end

    always_comb begin
        dup_cnt_d  = dup_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (dup_d && (dup_cnt_q != {CNT_W{1'b1}})) begin
            dup_cnt_d = dup_cnt_q + CNT_W'(1);
        end
        if (skip_d && (skip_cnt_q != {CNT_W{1'b1}})) begin
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q      <= '0;
            p_reg_q    <= 4'(P_RESET);
            p_prev_q   <= 4'(P_RESET);
            bits_q     <= '0;
            n_q        <= '0;
            dup_q      <= 1'b0;
            skip_q     <= 1'b0;
            err_q      <= 1'b0;
            dup_cnt_q  <= '0;
            skip_cnt_q <= '0;
        end else begin
            win_q      <= win_d;
            p_reg_q    <= p_reg_d;
            p_prev_q   <= p_prev_d;
            bits_q     <= bits_d;
            n_q        <= n_d;
            dup_q      <= dup_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
            dup_cnt_q  <= dup_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    deser400_bit_packer #(
        .SYM_W(SYM_W)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .bits     (bits_q),
        .n        (n_q),
        .sym      (sym),
        .sym_valid(sym_valid)
    );

    assign dup_evt   = dup_q;
    assign skip_evt  = skip_q;
    assign phase_err = err_q;
    assign dup_cnt   = dup_cnt_q;
    assign skip_cnt  = skip_cnt_q;

endmodule
